// File: rtl/multi_tick_timer.sv
// multi_tick_timer: a shared prescaler turns `clock` into ticks. NCHAN
// independent WIDTH-bit channel counters advance on every tick. Callers use
// a start/done interface to READ a channel, CLEAR it, or WAIT for it to
// advance by `arg` ticks.
//
// Optional feature: define MULTI_TICK_TIMER_WAIT_EN to build the blocking
// WAIT (WAITING state, target register and comparator). When the macro is
// undefined, op=WAIT completes like READ and busy is tied low.
module multi_tick_timer #(
    parameter int CLK_DIV = 100000,
    parameter int WIDTH   = 32,
    parameter int NCHAN   = 4,
    localparam int CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_port,
    input  logic [1:0]       op,
    input  logic [CW-1:0]    chan,
    input  logic [WIDTH-1:0] arg,
    output logic             done_port,
    output logic             busy,
    output logic [WIDTH-1:0] out1
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [1:0] OP_CLEAR = 2'd1;
`ifdef MULTI_TICK_TIMER_WAIT_EN
    localparam logic [1:0] OP_WAIT  = 2'd2;
`endif

    logic [PW-1:0]    presc;
    logic             tick;
    logic [WIDTH-1:0] count [NCHAN];
    logic             chan_ok;
    logic [WIDTH-1:0] rd_val;
    logic             clear_en;
    logic             done_next;
    logic [WIDTH-1:0] out1_next;

`ifdef MULTI_TICK_TIMER_WAIT_EN
    typedef enum logic {IDLE, WAITING} state_t;
    state_t           state, state_next;
    logic [WIDTH-1:0] target, target_next;
    logic [CW-1:0]    wait_chan, wait_chan_next;
    logic [WIDTH-1:0] wait_count;

    assign wait_count = count[wait_chan];
    assign busy       = (state == WAITING);
`else
    logic unused_arg;
    assign unused_arg = ^arg;
    assign busy       = 1'b0;
`endif

    assign tick    = (presc == PRESC_LAST);
    // Out-of-range channels behave as a READ of zero and never touch state.
    assign chan_ok = (int'(chan) < NCHAN);
    assign rd_val  = chan_ok ? count[chan] : '0;

    // Prescaler: free-running 0..CLK_DIV-1, tick on the last count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Channel counters: a CLEAR wins over a coincident tick on its own channel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCHAN; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (clear_en && (chan == CW'(i))) begin
                    count[i] <= '0;
                end else if (tick) begin
                    count[i] <= count[i] + 1'b1;
                end
            end
        end
    end

    // Call decode and completion: next out1/done, and the WAIT bookkeeping.
    always_comb begin
        done_next = 1'b0;
        out1_next = out1;
        clear_en  = 1'b0;
`ifdef MULTI_TICK_TIMER_WAIT_EN
        state_next     = state;
        target_next    = target;
        wait_chan_next = wait_chan;
        if (state == WAITING) begin
            // Counts step by one, so equality is always hit, even across wrap.
            if (wait_count == target) begin
                out1_next  = target;
                done_next  = 1'b1;
                state_next = IDLE;
            end
        end else if (start_port) begin
            if ((op == OP_WAIT) && (arg != '0) && chan_ok) begin
                target_next    = rd_val + arg;
                wait_chan_next = chan;
                state_next     = WAITING;
            end else begin
                out1_next = rd_val;
                done_next = 1'b1;
                clear_en  = (op == OP_CLEAR) && chan_ok;
            end
        end
`else
        if (start_port) begin
            out1_next = rd_val;
            done_next = 1'b1;
            clear_en  = (op == OP_CLEAR) && chan_ok;
        end
`endif
    end

    // Result and completion registers; done is a single-cycle pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_port <= 1'b0;
            out1      <= '0;
        end else begin
            done_port <= done_next;
            out1      <= out1_next;
        end
    end

`ifdef MULTI_TICK_TIMER_WAIT_EN
    // WAIT state register: reset aborts any pending wait without a done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            target    <= '0;
            wait_chan <= '0;
        end else begin
            state     <= state_next;
            target    <= target_next;
            wait_chan <= wait_chan_next;
        end
    end
`endif

endmodule

// File: tb/tb_multi_tick_timer.sv
// Bench for multi_tick_timer with CLK_DIV=4, NCHAN=2, WIDTH=8.
// Directed calls are scheduled on absolute clock edges counted from reset
// release; after edge e (no clears) every channel holds e/4. Each call that
// should complete pushes its expected out1 and completion edge into a queue;
// a monitor pops and compares whenever done_port is seen.
`timescale 1ns/1ps
module tb_multi_tick_timer;

    localparam int CLK_DIV = 4;
    localparam int WIDTH   = 8;
    localparam int NCHAN   = 2;
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_WAIT  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start_port = 1'b0;
    logic [1:0]       op = 2'd0;
    logic             chan = 1'b0;
    logic [WIDTH-1:0] arg = '0;
    logic             done_port;
    logic             busy;
    logic [WIDTH-1:0] out1;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               edge_no;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt;

    multi_tick_timer #(
        .CLK_DIV(CLK_DIV),
        .WIDTH  (WIDTH),
        .NCHAN  (NCHAN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start_port(start_port),
        .op        (op),
        .chan      (chan),
        .arg       (arg),
        .done_port (done_port),
        .busy      (busy),
        .out1      (out1)
    );

    always #5 clock = ~clock;

    // Edge number since the last reset release (first edge after release = 1).
    always @(posedge clock or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && done_port) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_port=1 at edge %0d out1=%0d, expected no completion",
                         edge_cnt, out1);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_out1"}, int'(out1), int'(e.val));
                check({e.name, "_edge"}, edge_cnt, e.edge_no);
            end
        end
    end

    task automatic wait_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present a call so that it is sampled on edge e.
    task automatic call_at(input string name, input int e, input logic [1:0] o,
                           input logic c, input logic [WIDTH-1:0] a,
                           input logic expect_done, input logic [WIDTH-1:0] exp_val,
                           input int exp_edge);
        if (edge_cnt >= e) begin
            checks++;
            errors++;
            $display("FAIL %s_schedule: got edge %0d, expected before %0d", name, edge_cnt, e);
        end
        wait_edge(e - 1);
        @(negedge clock);
        start_port = 1'b1;
        op         = o;
        chan       = c;
        arg        = a;
        if (expect_done) exp_q.push_back('{val: exp_val, edge_no: exp_edge, name: name});
        @(posedge clock);
        #1;
        start_port = 1'b0;
        op         = OP_READ;
        arg        = '0;
    endtask

    initial begin
        #12;
        check("rst_done", done_port, 0);
        check("rst_busy", busy, 0);
        check("rst_out1", out1, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        call_at("rd0_e10",       10, OP_READ,  1'b0, 8'd0, 1'b1, 8'd2,  10);
        call_at("rd1_e12",       12, OP_READ,  1'b1, 8'd0, 1'b1, 8'd2,  12);
        call_at("clr1_tick",     24, OP_CLEAR, 1'b1, 8'd0, 1'b1, 8'd5,  24);
        call_at("rd1_after_clr", 26, OP_READ,  1'b1, 8'd0, 1'b1, 8'd0,  26);
        call_at("rd0_after_clr", 27, OP_READ,  1'b0, 8'd0, 1'b1, 8'd6,  27);
`ifdef MULTI_TICK_TIMER_WAIT_EN
        call_at("wait0_k3",      30, OP_WAIT,  1'b0, 8'd3, 1'b1, 8'd10, 41);
        wait_edge(31);
        check("busy_waiting", busy, 1);
        call_at("ignored_start", 35, OP_READ,  1'b1, 8'd0, 1'b0, 8'd0,  0);
        check("busy_after_ignored", busy, 1);
        wait_edge(40);
        check("busy_at_target_edge", busy, 1);
        wait_edge(41);
        check("busy_after_done", busy, 0);
        call_at("wait1_zero",    45, OP_WAIT,  1'b1, 8'd0, 1'b1, 8'd5,  45);
        check("busy_zero_wait", busy, 0);
        call_at("rsvd_op",       50, OP_RSVD,  1'b0, 8'd0, 1'b1, 8'd12, 50);
        call_at("wait0_wrap",  1018, OP_WAIT,  1'b0, 8'd3, 1'b1, 8'd1,  1029);
        wait_edge(1030);
        call_at("wait1_abort", 1040, OP_WAIT,  1'b1, 8'd10, 1'b0, 8'd0, 0);
        check("busy_before_abort", busy, 1);
`else
        call_at("rsvd_op",       30, OP_RSVD,  1'b0, 8'd0, 1'b1, 8'd7,  30);
        call_at("rd1_e33",       33, OP_READ,  1'b1, 8'd0, 1'b1, 8'd2,  33);
        call_at("wait_as_read",  36, OP_WAIT,  1'b0, 8'd5, 1'b1, 8'd8,  36);
        check("busy_wait_off", busy, 0);
        wait_edge(40);
        check("busy_wait_off_later", busy, 0);
        call_at("rd0_pre_wrap", 1018, OP_READ, 1'b0, 8'd0, 1'b1, 8'd254, 1018);
        call_at("rd0_wrapped",  1026, OP_READ, 1'b0, 8'd0, 1'b1, 8'd0,   1026);
        call_at("rd1_pre_reset",1040, OP_READ, 1'b1, 8'd0, 1'b1, 8'd253, 1040);
`endif
        wait_edge(1043);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_done", done_port, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out1", out1, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        call_at("rd1_post_rst",   3, OP_READ, 1'b1, 8'd0, 1'b1, 8'd0, 3);
        call_at("rd0_pre_tick",   4, OP_READ, 1'b0, 8'd0, 1'b1, 8'd0, 4);
        call_at("rd0_first_tick", 5, OP_READ, 1'b0, 8'd0, 1'b1, 8'd1, 5);
        wait_edge(60);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
